mem_access_sequencer: RTL and testbench

- Multi-cycle sequencer between the core datapath and the data RAM for LW/LH/LHU/LB/SW/SH/SB.
- Takes a decoded memory request (RAMEnable/RW/size), drives the RAM enable/RW/byte-enable handshake, and waits for MOC.
- Stalls the core while the access is outstanding, then returns lane-aligned, sign- or zero-extended load data.
- Flags misaligned accesses and MOC timeouts.

---
 rtl/mem_access_sequencer_if.sv | 38 +++
 rtl/mem_access_sequencer.sv | 141 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Core/RAM bundle for the memory access sequencer: request, RAM handshake, load result.
// Latency: none (wires only).
// Backpressure: the sequencer holds the core via stall while a RAM access is outstanding.
interface mem_access_sequencer_if;
  // core request side
  logic        start;
  logic        rw;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  // RAM side
  logic        MOC;
  logic [31:0] ram_rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  // results back to the core
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;

  // sequencer view
  modport slave (
    input  start, rw, size, load_unsigned, addr, wdata, MOC, ram_rdata,
    output mem_en, mem_rw, mem_addr, mem_be, mem_wdata, stall, done, rdata, err, err_code
  );

  // core + RAM view
  modport master (
    output start, rw, size, load_unsigned, addr, wdata, MOC, ram_rdata,
    input  mem_en, mem_rw, mem_addr, mem_be, mem_wdata, stall, done, rdata, err, err_code
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences one load/store to the data RAM: byte enables, lane replication, MOC wait, load extension.
// Latency: start -> mem_en next cycle -> done one cycle after MOC; misaligned -> err next cycle.
// Backpressure: stall holds the core from an accepted start until MOC or timeout.
module mem_access_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic                  clk,
  input logic                  reset,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  lat_lo;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rdata_nxt;
  logic [31:0] rd_shift;

  // alignment check, byte enables and store-lane replication for the incoming request
  always_comb begin
    misaligned = 1'b0;
    be_nxt     = 4'b1111;
    wdata_nxt  = bus.wdata;
    case (bus.size)
      2'b00: begin
        be_nxt    = 4'b0001 << bus.addr[1:0];
        wdata_nxt = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        misaligned = bus.addr[0];
        be_nxt     = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt  = {2{bus.wdata[15:0]}};
      end
      default: misaligned = (bus.addr[1:0] != 2'b00);
    endcase
  end

  // last wait cycle allowed before giving up on MOC; TIMEOUT=0 never expires
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  // pick the addressed lane out of the RAM word and extend it
  always_comb begin
    rd_shift  = bus.ram_rdata >> {lat_lo, 3'b000};
    rdata_nxt = bus.ram_rdata;
    case (lat_size)
      2'b00:   rdata_nxt = lat_uns ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rdata_nxt = lat_uns ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rdata_nxt = bus.ram_rdata;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; MOC takes priority over the timeout limit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = misaligned ? ERR : BUSY;
      BUSY: begin
        if (bus.MOC)        state_nxt = DONE;
        else if (timeout_hit) state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stall is the only combinational output: accepted request or outstanding access
  always_comb begin
    bus.stall = ((state == IDLE) && bus.start && !misaligned) || (state == BUSY);
  end

  // registered outputs, request latches and the MOC wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_rw    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_be    <= 4'h0;
      bus.mem_wdata <= 32'h0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_code  <= 2'b00;
      bus.rdata     <= 32'h0;
      cnt           <= '0;
      lat_size      <= 2'b00;
      lat_uns       <= 1'b0;
      lat_lo        <= 2'b00;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (misaligned) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'b01;
            end else begin
              bus.mem_en    <= 1'b1;
              bus.mem_rw    <= bus.rw;
              bus.mem_addr  <= {bus.addr[31:2], 2'b00};
              bus.mem_be    <= be_nxt;
              bus.mem_wdata <= wdata_nxt;
              bus.err_code  <= 2'b00;
              cnt           <= '0;
              lat_size      <= bus.size;
              lat_uns       <= bus.load_unsigned;
              lat_lo        <= bus.addr[1:0];
            end
          end
        end
        BUSY: begin
          if (bus.MOC) begin
            bus.mem_en <= 1'b0;
            bus.done   <= 1'b1;
            if (bus.mem_rw) bus.rdata <= rdata_nxt;
          end else if (timeout_hit) begin
            bus.mem_en   <= 1'b0;
            bus.err      <= 1'b1;
            bus.err_code <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer (TIMEOUT=4): directed cases then random accesses.
// Latency: checks cycle positions of mem_en, done and err against the request start.
// Backpressure: checks stall on every cycle of each access.
module tb_mem_access_sequencer;

  localparam int TO = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_err_code;

  mem_access_sequencer_if bus();

  mem_access_sequencer #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // reference rules, in plain arithmetic on the byte offset
  function automatic bit f_mis(input int sz, input int off);
    if (sz == 1) return (off % 2) != 0;
    if (sz >= 2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_be(input int sz, input int off);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wd(input int sz, input logic [31:0] wd);
    if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] f_ld(input int sz, input int off, input bit uns, input logic [31:0] r);
    logic [31:0] v;
    if (sz == 0) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (r >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // one request from IDLE; delay = MOC-low BUSY cycles before MOC (>= TO means never)
  task automatic do_access(input bit rw_i, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int delay, input logic [31:0] rr);
    int  off;
    bit  mis;
    bit  finished;
    off = int'(a % 4);
    mis = f_mis(int'(sz), off);
    chk("idle_err_code", {30'b0, bus.err_code}, {30'b0, exp_err_code});
    bus.start = 1'b1; bus.rw = rw_i; bus.size = sz; bus.load_unsigned = uns;
    bus.addr = a; bus.wdata = wd; bus.MOC = 1'b0; bus.ram_rdata = 32'h0;
    #1;
    chk("start_stall", {31'b0, bus.stall}, {31'b0, !mis});
    cyc();
    bus.start = 1'b0;
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    #1;
    if (mis) begin
      chk("mis_err", {31'b0, bus.err}, 32'd1);
      chk("mis_code", {30'b0, bus.err_code}, 32'd1);
      chk("mis_mem_en", {31'b0, bus.mem_en}, 32'd0);
      chk("mis_stall", {31'b0, bus.stall}, 32'd0);
      exp_err_code = 2'b01;
      cyc();
      chk("mis_err_pulse", {31'b0, bus.err}, 32'd0);
      return;
    end
    finished = 1'b0;
    for (int k = 0; k < TO && !finished; k++) begin
      chk("busy_mem_en", {31'b0, bus.mem_en}, 32'd1);
      chk("busy_stall", {31'b0, bus.stall}, 32'd1);
      chk("busy_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
      chk("busy_be", {28'b0, bus.mem_be}, {28'b0, f_be(int'(sz), off)});
      chk("busy_wdata", bus.mem_wdata, f_wd(int'(sz), wd));
      chk("busy_rw", {31'b0, bus.mem_rw}, {31'b0, rw_i});
      chk("busy_done", {31'b0, bus.done}, 32'd0);
      if (k == 0) chk("busy_code_clr", {30'b0, bus.err_code}, 32'd0);
      exp_err_code = 2'b00;
      bus.MOC       = (k == delay);
      bus.ram_rdata = (k == delay) ? rr : $urandom;
      cyc();
      bus.MOC = 1'b0;
      bus.ram_rdata = $urandom;
      #1;
      if (k == delay) begin
        finished = 1'b1;
        if (rw_i) exp_rdata = f_ld(int'(sz), off, uns, rr);
        chk("done_pulse", {31'b0, bus.done}, 32'd1);
        chk("done_mem_en", {31'b0, bus.mem_en}, 32'd0);
        chk("done_stall", {31'b0, bus.stall}, 32'd0);
        chk("done_rdata", bus.rdata, exp_rdata);
        chk("done_err", {31'b0, bus.err}, 32'd0);
        cyc();
        chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
      end
    end
    if (!finished) begin
      exp_err_code = 2'b10;
      chk("to_err", {31'b0, bus.err}, 32'd1);
      chk("to_code", {30'b0, bus.err_code}, 32'd2);
      chk("to_mem_en", {31'b0, bus.mem_en}, 32'd0);
      chk("to_stall", {31'b0, bus.stall}, 32'd0);
      chk("to_done", {31'b0, bus.done}, 32'd0);
      cyc();
      chk("to_err_pulse", {31'b0, bus.err}, 32'd0);
      chk("to_code_held", {30'b0, bus.err_code}, 32'd2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_rdata    = 32'h0;
    exp_err_code = 2'b00;
    reset = 1'b0;
    bus.start = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.load_unsigned = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.MOC = 1'b0; bus.ram_rdata = 32'h0;
    cyc(); cyc();
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_flags", {28'b0, bus.done, bus.err, bus.err_code}, 32'h0);
    reset = 1'b1;
    cyc();

    // MOC in IDLE is ignored
    bus.MOC = 1'b1;
    cyc(); cyc();
    chk("idle_moc_en", {31'b0, bus.mem_en}, 32'd0);
    chk("idle_moc_done", {31'b0, bus.done}, 32'd0);
    chk("idle_moc_stall", {31'b0, bus.stall}, 32'd0);
    bus.MOC = 1'b0;

    // directed cases
    do_access(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    do_access(1'b1, 2'b00, 1'b0, 32'h203, 32'h0, 1, 32'h8012_3456);
    do_access(1'b1, 2'b00, 1'b1, 32'h203, 32'h0, 0, 32'h8012_3456);
    do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 0, 32'h1111_1111);
    do_access(1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 0, 32'h0);
    do_access(1'b1, 2'b11, 1'b0, 32'h104, 32'h0, 2, 32'h1234_5678);
    do_access(1'b1, 2'b10, 1'b0, 32'h108, 32'h0, 99, 32'h0);
    do_access(1'b1, 2'b01, 1'b0, 32'h10A, 32'h0, 3, 32'h9876_0000);

    // reset two cycles into BUSY: mem_en drops at once, no pulse afterwards
    bus.start = 1'b1; bus.rw = 1'b1; bus.size = 2'b10; bus.addr = 32'h40;
    cyc();
    bus.start = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("mid_rst_stall", {31'b0, bus.stall}, 32'd0);
    bus.MOC = 1'b1;
    cyc();
    bus.MOC = 1'b0;
    chk("mid_rst_flags", {30'b0, bus.done, bus.err}, 32'd0);
    chk("mid_rst_rdata", bus.rdata, 32'h0);
    reset = 1'b1;
    exp_rdata = 32'h0;
    exp_err_code = 2'b00;
    cyc();
    chk("post_rst_flags", {29'b0, bus.mem_en, bus.done, bus.err}, 32'd0);
    do_access(1'b1, 2'b10, 1'b0, 32'h44, 32'h0, 1, 32'hCAFE_F00D);

    // random accesses
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                $urandom, int'($urandom_range(0, 5)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
